// File: rtl/jt10_adpcm_enca_pkg.sv
// Shared ADPCM-A constants: step table, index adaptation and encoder FSM encoding.
// These match the decoder so that the encoder's reconstruction tracks it exactly.
package jt10_adpcmA_pkg;

  localparam int ACC_W = 12;
  localparam int IDX_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIFF,
    ST_SA2,
    ST_SA1,
    ST_SA0,
    ST_UPD,
    ST_EMIT
  } state_t;

  function automatic logic [11:0] step_lut(input logic [IDX_W-1:0] idx);
    logic [11:0] s;
    case (idx)
      6'd0:  s = 12'd16;   6'd1:  s = 12'd17;   6'd2:  s = 12'd19;   6'd3:  s = 12'd21;
      6'd4:  s = 12'd23;   6'd5:  s = 12'd25;   6'd6:  s = 12'd28;   6'd7:  s = 12'd31;
      6'd8:  s = 12'd34;   6'd9:  s = 12'd37;   6'd10: s = 12'd41;   6'd11: s = 12'd45;
      6'd12: s = 12'd50;   6'd13: s = 12'd55;   6'd14: s = 12'd60;   6'd15: s = 12'd66;
      6'd16: s = 12'd73;   6'd17: s = 12'd80;   6'd18: s = 12'd88;   6'd19: s = 12'd97;
      6'd20: s = 12'd107;  6'd21: s = 12'd118;  6'd22: s = 12'd130;  6'd23: s = 12'd143;
      6'd24: s = 12'd157;  6'd25: s = 12'd173;  6'd26: s = 12'd190;  6'd27: s = 12'd209;
      6'd28: s = 12'd230;  6'd29: s = 12'd253;  6'd30: s = 12'd279;  6'd31: s = 12'd307;
      6'd32: s = 12'd337;  6'd33: s = 12'd371;  6'd34: s = 12'd408;  6'd35: s = 12'd449;
      6'd36: s = 12'd494;  6'd37: s = 12'd544;  6'd38: s = 12'd598;  6'd39: s = 12'd658;
      6'd40: s = 12'd724;  6'd41: s = 12'd796;  6'd42: s = 12'd876;  6'd43: s = 12'd963;
      6'd44: s = 12'd1060; 6'd45: s = 12'd1166; 6'd46: s = 12'd1282; 6'd47: s = 12'd1411;
      default: s = 12'd1552;
    endcase
    return s;
  endfunction

  function automatic logic signed [4:0] idx_adj(input logic [2:0] m);
    logic signed [4:0] a;
    case (m)
      3'd4:    a = 5'sd2;
      3'd5:    a = 5'sd5;
      3'd6:    a = 5'sd7;
      3'd7:    a = 5'sd9;
      default: a = -5'sd1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/jt10_adpcm_enca_if.sv
// Control, PCM input and packed-byte output bundle of the ADPCM-A encoder.
interface jt10_adpcm_enca_if #(parameter int ADDR_W = 20);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              flush;
  logic [15:0]       pcm_in;
  logic              pcm_valid;
  logic              pcm_ready;
  logic [7:0]        dout;
  logic [ADDR_W-1:0] dout_addr;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic [11:0]       recon;

  modport master (
    output start, start_addr, flush, pcm_in, pcm_valid, dout_ready,
    input  pcm_ready, dout, dout_addr, dout_valid, busy, recon
  );

  modport slave (
    input  start, start_addr, flush, pcm_in, pcm_valid, dout_ready,
    output pcm_ready, dout, dout_addr, dout_valid, busy, recon
  );
endinterface

// File: rtl/jt10_adpcm_enca_quant.sv
// One successive-approximation step plus the decoder-identical delta/clip/index update.
// Purely combinational; the caller sequences the stages and holds all state.
module jt10_adpcmA_quant
  import jt10_adpcmA_pkg::*;
(
  input  logic [12:0]             mag,
  input  logic [11:0]             step,
  input  logic [1:0]              stage_shift,
  input  logic [2:0]              m,
  input  logic                    sign,
  input  logic signed [ACC_W-1:0] acc,
  input  logic [IDX_W-1:0]        idx,
  output logic                    nib_bit,
  output logic [12:0]             mag_next,
  output logic signed [ACC_W-1:0] acc_next,
  output logic [IDX_W-1:0]        idx_next
);

  localparam logic signed [13:0] ACC_HI = 14'sd2047;
  localparam logic signed [13:0] ACC_LO = -14'sd2048;

  logic [12:0]        cmp;
  logic [15:0]        prod;
  logic [12:0]        delta;
  logic signed [13:0] acc_ext;
  logic signed [13:0] sum;
  logic signed [6:0]  idx_sum;

  always_comb begin
    cmp      = {1'b0, step} >> stage_shift;
    nib_bit  = (mag >= cmp);
    mag_next = nib_bit ? (mag - cmp) : mag;

    prod    = {12'd0, m, 1'b1} * {4'd0, step};
    delta   = 13'(prod >> 3);
    acc_ext = $signed({{2{acc[ACC_W-1]}}, acc});
    sum     = sign ? (acc_ext - $signed({1'b0, delta})) : (acc_ext + $signed({1'b0, delta}));

    if (sum > ACC_HI)      acc_next = ACC_HI[ACC_W-1:0];
    else if (sum < ACC_LO) acc_next = ACC_LO[ACC_W-1:0];
    else                   acc_next = sum[ACC_W-1:0];

    idx_sum = $signed({1'b0, idx}) + 7'(idx_adj(m));
    if (idx_sum < 7'sd0)       idx_next = '0;
    else if (idx_sum > 7'sd48) idx_next = 6'd48;
    else                       idx_next = idx_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/jt10_adpcm_enca.sv
// ADPCM-A encoder: 16-bit PCM in, two 4-bit nibbles packed per byte at incrementing ROM addresses.
// Six cycles per sample; pcm_ready drops while encoding or while a byte waits on dout_ready.
module jt10_adpcm_enca
  import jt10_adpcmA_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int IN_SHIFT = 4
) (
  input logic               clk,
  input logic               rst,
  jt10_adpcm_enca_if.slave  bus
);

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc, target, recon_q;
  logic [IDX_W-1:0]        idx;
  logic                    half, flush_pend, ready_q, dout_valid_q, sign;
  logic [7:0]              dout_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [12:0]             mag;
  logic [ACC_W:0]          diff;
  logic [2:0]              m;
  logic [1:0]              sa_shift;
  logic [11:0]             step;
  logic                    accept, flush_now;

  logic                    nib_bit;
  logic [12:0]             mag_next;
  logic signed [ACC_W-1:0] acc_next;
  logic [IDX_W-1:0]        idx_next;

  assign step      = step_lut(idx);
  assign accept    = bus.pcm_valid && ready_q;
  assign flush_now = (bus.flush || flush_pend) && half;
  assign diff      = {target[ACC_W-1], target} - {acc[ACC_W-1], acc};

  jt10_adpcmA_quant u_quant (
    .mag        (mag),
    .step       (step),
    .stage_shift(sa_shift),
    .m          (m),
    .sign       (sign),
    .acc        (acc),
    .idx        (idx),
    .nib_bit    (nib_bit),
    .mag_next   (mag_next),
    .acc_next   (acc_next),
    .idx_next   (idx_next)
  );

  always_comb begin
    state_nx = state;
    sa_shift = 2'd0;
    case (state)
      ST_IDLE: begin
        if (accept)         state_nx = ST_DIFF;
        else if (flush_now) state_nx = ST_EMIT;
      end
      ST_DIFF: state_nx = ST_SA2;
      ST_SA2:  begin sa_shift = 2'd0; state_nx = ST_SA1; end
      ST_SA1:  begin sa_shift = 2'd1; state_nx = ST_SA0; end
      ST_SA0:  begin sa_shift = 2'd2; state_nx = ST_UPD; end
      ST_UPD:  state_nx = half ? ST_EMIT : ST_IDLE;
      ST_EMIT: if (bus.dout_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (bus.start) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0; idx <= '0; half <= 1'b0; target <= '0; mag <= '0; sign <= 1'b0;
      m <= '0; flush_pend <= 1'b0; ready_q <= 1'b0; dout_q <= '0;
      dout_valid_q <= 1'b0; addr_q <= '0; recon_q <= '0;
    end else if (bus.start) begin
      acc <= '0; idx <= '0; half <= 1'b0; dout_valid_q <= 1'b0;
      addr_q <= bus.start_addr; flush_pend <= 1'b0; recon_q <= '0; ready_q <= 1'b1;
    end else begin
      ready_q <= (state_nx == ST_IDLE);
      if (bus.flush && state != ST_IDLE) flush_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          // A sample offered alongside a flush wins; the flush then waits for the next IDLE.
          if (accept) begin
            target     <= ACC_W'($signed(bus.pcm_in) >>> IN_SHIFT);
            flush_pend <= flush_pend | bus.flush;
          end else begin
            flush_pend <= 1'b0;
            if (flush_now) begin
              dout_q[3:0]  <= 4'h0;
              dout_valid_q <= 1'b1;
              half         <= 1'b0;
            end
          end
        end
        ST_DIFF: begin
          sign <= diff[ACC_W];
          mag  <= diff[ACC_W] ? (13'd0 - diff) : diff;
          m    <= '0;
        end
        ST_SA2: begin m[2] <= nib_bit; mag <= mag_next; end
        ST_SA1: begin m[1] <= nib_bit; mag <= mag_next; end
        ST_SA0: begin m[0] <= nib_bit; mag <= mag_next; end
        ST_UPD: begin
          acc     <= acc_next;
          idx     <= idx_next;
          recon_q <= acc_next;
          if (!half) begin
            dout_q[7:4] <= {sign, m};
            half        <= 1'b1;
          end else begin
            dout_q[3:0]  <= {sign, m};
            dout_valid_q <= 1'b1;
            half         <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            addr_q       <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pcm_ready  = ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_addr  = addr_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state != ST_IDLE) || dout_valid_q;
  assign bus.recon      = recon_q;

endmodule
